// File: rtl/plic_gateway_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_gateway_pkg;

  localparam int unsigned PLIC_ID_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    INFLIGHT = 2'd2
  } gw_state_t;

endpackage

// File: rtl/plic_gateway_src.sv
// One interrupt source: level/edge gateway FSM, edge counter and sticky overflow flag.
module plic_gateway_src
  import plic_gateway_pkg::*;
#(
  parameter int unsigned ID    = 1,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_irq,
  input  logic                 edge_mode,
  input  logic                 claim_valid,
  input  logic [PLIC_ID_W-1:0] claim_id,
  input  logic                 complete_valid,
  input  logic [PLIC_ID_W-1:0] complete_id,
  input  logic                 ovf_clr,
  output logic                 req,
  output logic                 inflight,
  output logic                 overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gw_state_t        r_state;
  gw_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_src_q;
  logic             r_ovf;
  logic             r_req;
  logic             r_inflight;
  logic             w_edge;
  logic             w_claim_hit;
  logic             w_comp_hit;
  logic             w_ovf_set;
  logic             w_has_work;

  assign w_edge      = src_irq & ~r_src_q;
  assign w_claim_hit = claim_valid && (claim_id == PLIC_ID_W'(ID)) && (r_state == PEND);
  assign w_comp_hit  = complete_valid && (complete_id == PLIC_ID_W'(ID)) && (r_state == INFLIGHT);
  // Work still outstanding when a completion retires the current request
  assign w_has_work  = edge_mode ? (r_cnt != '0) : src_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_src_q    <= 1'b0;
      r_ovf      <= 1'b0;
      r_req      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_src_q    <= src_irq;
      r_ovf      <= (r_ovf & ~ovf_clr) | w_ovf_set;
      r_req      <= (w_state_nxt == PEND);
      r_inflight <= (w_state_nxt == INFLIGHT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ovf_set   = 1'b0;

    // Edge + claim together leave the count unchanged; saturation loses the edge
    if (!edge_mode) begin
      w_cnt_nxt = '0;
    end else if (w_edge && !w_claim_hit) begin
      if (r_cnt == CNT_MAX) begin
        w_ovf_set = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (!w_edge && w_claim_hit && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (edge_mode ? (w_cnt_nxt != '0) : src_irq) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (w_claim_hit) begin
          w_state_nxt = INFLIGHT;
        end
      end
      INFLIGHT: begin
        if (w_comp_hit) begin
          w_state_nxt = w_has_work ? PEND : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req      = r_req;
  assign inflight = r_inflight;
  assign overflow = r_ovf;

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway: NUM_SRC independent per-source gateways between raw IRQ wires and the PLIC core.
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter int unsigned NUM_SRC = 10,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC:1]     src_irq,
  input  logic [NUM_SRC:1]     edge_mode,
  input  logic                 claim_valid,
  input  logic [PLIC_ID_W-1:0] claim_id,
  input  logic                 complete_valid,
  input  logic [PLIC_ID_W-1:0] complete_id,
  input  logic                 ovf_clr,
  output logic [NUM_SRC:1]     req,
  output logic [NUM_SRC:1]     inflight,
  output logic [NUM_SRC:1]     overflow
);

  // Source IDs start at 1; ID 0 is the "no interrupt" ID and matches nothing
  for (genvar g = 1; g <= int'(NUM_SRC); g++) begin : g_src
    plic_gateway_src #(
      .ID    (g),
      .CNT_W (CNT_W)
    ) u_src (
      .clk            (clk),
      .reset          (reset),
      .src_irq        (src_irq[g]),
      .edge_mode      (edge_mode[g]),
      .claim_valid    (claim_valid),
      .claim_id       (claim_id),
      .complete_valid (complete_valid),
      .complete_id    (complete_id),
      .ovf_clr        (ovf_clr),
      .req            (req[g]),
      .inflight       (inflight[g]),
      .overflow       (overflow[g])
    );
  end

endmodule

// File: doc/plic_gateway.md
PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 Parameter NUM_SRC, default 10, number of interrupt sources, IDs 1..NUM_SRC, legal range 1..63.
REQ-002 Parameter CNT_W, default 3, width of the per-source edge counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 src_irq  in  [NUM_SRC:1]  raw interrupt wires, synchronous to clk.
REQ-006 edge_mode  in  [NUM_SRC:1]  per-source trigger type: 1 = rising-edge, 0 = level-high.
REQ-007 claim_valid  in  1  PLIC core reports a claim this cycle.
REQ-008 claim_id  in  6  claimed source ID.
REQ-009 complete_valid  in  1  PLIC core reports a completion this cycle.
REQ-010 complete_id  in  6  completed source ID.
REQ-011 ovf_clr  in  1  clears all overflow bits.
REQ-012 req  out  [NUM_SRC:1]  registered pending request to the PLIC core.
REQ-013 inflight  out  [NUM_SRC:1]  source claimed and not yet completed.
REQ-014 overflow  out  [NUM_SRC:1]  sticky flag: an edge was lost because the counter was saturated.

Function
REQ-015 Each source runs an independent FSM with three states: IDLE, PEND, INFLIGHT.
- req[i] = (state == PEND).
- inflight[i] = (state == INFLIGHT).
- Both are direct flop outputs.
REQ-016 Each source registers src_irq into src_q every cycle; edge[i] = src_irq[i] & ~src_q[i].
REQ-017 Level mode, IDLE: src_irq high at rising edge N -> PEND; req high from cycle N+1 (1-cycle latency).
REQ-018 Level mode, PEND: remains PEND even if src_irq drops (no retraction); leaves only on claim.
REQ-019 Edge mode counter cnt[i]:
- +1 on edge[i].
- -1 on an accepted claim of source i.
- Both in the same cycle: net unchanged.
REQ-020 cnt saturates at 2^CNT_W-1; an edge arriving while saturated (and no simultaneous claim) sets overflow[i].
REQ-021 Edge mode, IDLE -> PEND when the next-state cnt is nonzero.
REQ-022 Claim acceptance:
- Accepted only when claim_valid, claim_id == i, and state == PEND.
- Effect: PEND -> INFLIGHT.
- Claims with ID 0, ID > NUM_SRC, or targeting a non-PEND source are ignored.
REQ-023 Completion acceptance:
- Accepted only when complete_valid, complete_id == i, and state == INFLIGHT.
- Otherwise ignored, with no state change.
REQ-024 On accepted complete, the next state is:
- PEND if (level mode and src_irq[i]) or (edge mode and cnt[i] != 0);
- else IDLE.
REQ-025 Edges arriving in INFLIGHT are counted (edge mode) and never dropped except on saturation.
REQ-026 Claim and complete for the same ID in the same cycle: only the one matching the current state acts.
REQ-027 In level mode cnt is forced to 0; a mode change takes effect in the next cycle without altering state.
REQ-028 Overflow clearing:
- ovf_clr clears all overflow bits.
- A simultaneous new overflow wins (bit stays set).

Reset
REQ-029 While reset is high at a clock edge:
- every state -> IDLE;
- cnt = 0, src_q = 0, overflow = 0;
- therefore req = 0 and inflight = 0 from the following cycle.
REQ-030 Reset mid-operation discards all pending, inflight and counted edges; no completion is required afterwards.

Structure
REQ-031 The shared package holds:
- the enum gw_state_t {IDLE, PEND, INFLIGHT};
- the constant PLIC_ID_W = 6 for claim/complete ID width.
REQ-032 Sub-module plic_gateway_src implements one source's FSM, counter and overflow; plic_gateway instantiates NUM_SRC copies in a generate loop.
REQ-033 ID decode (claim_id/complete_id compare) is done in plic_gateway_src against a per-instance ID parameter.

Verification
REQ-034 Level: edge_mode=0, src_irq[3]=1 at cycle 5:
- req[3]=1 at cycle 6;
- claim_id=3 at cycle 8 -> inflight[3]=1 and req[3]=0 at cycle 9;
- complete_id=3 with src_irq[3] still 1 -> req[3]=1 the next cycle.
REQ-035 Edge counting: edge_mode[2]=1, three pulses on src_irq[2]:
- claim/complete repeated three times yields exactly three req[2] assertions;
- fourth claim ignored, req[2]=0.
REQ-036 Saturation: CNT_W=3, 8 edges on source 1 with no claim:
- overflow[1]=1 after the 8th edge;
- ovf_clr -> overflow[1]=0 next cycle.
REQ-037 Illegal handshakes are ignored, with state unchanged:
- claim_id=0;
- claim_id=11 (NUM_SRC=10);
- complete_id=4 while source 4 is IDLE.
REQ-038 Simultaneous: edge and accepted claim on source 2 in the same cycle with cnt=2 -> cnt stays 2 and the source is INFLIGHT.
REQ-039 Reset: reset asserted while source 5 is INFLIGHT with cnt=3 -> the next cycle has inflight=0, req=0 and a later claim_id=5 is ignored.
